vga_fb_arbiter: RTL and testbench
=================================

VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 SHALL have parameter PIX_W, default 24, pixel width in bits.
REQ-002 SHALL have parameter FB_ADDR_W, default 19, framebuffer word-address width.
REQ-003 SHALL have parameter H_VIS, default 640, visible pixels per line.
REQ-004 SHALL have parameter V_VIS, default 480, visible lines per frame.
REQ-005 SHALL have parameter WBUF_DEPTH, default 4 (power of two, >=2), write-buffer entries.
REQ-006 SHALL have port clk_25_175M  in  1  sole clock, VGA pixel domain.
REQ-007 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have port scan_req  in  1  scanout fetch request for this cycle.
REQ-009 SHALL have ports scan_hidx and scan_vidx  in  10 each  screen-space pixel coordinates.
REQ-010 SHALL have port scan_pix  out  PIX_W  fetched pixel, valid 2 cycles after scan_req.
REQ-011 SHALL have ports wr_valid in 1, wr_ready out 1, wr_addr in FB_ADDR_W, wr_data in PIX_W  writer handshake.
REQ-012 SHALL have ports mem_en, mem_we out 1; mem_addr out FB_ADDR_W; mem_wdata out PIX_W; mem_rdata in PIX_W  single-port sync RAM, 1-cycle read latency.
REQ-013 SHALL have port wr_drop  out  1  sticky flag: out-of-range write discarded.

Function
REQ-014 Write transfer SHALL occur on a clock edge where wr_valid and wr_ready are both 1; the entry enters the write buffer (FIFO).
REQ-015 wr_ready SHALL be 1 exactly when the buffer is not full; a push and a pop on the same full-buffer cycle SHALL NOT be accepted (ready based on registered count).
REQ-016 A write with wr_addr >= H_VIS*V_VIS SHALL be accepted, discarded, and set wr_drop until reset.
REQ-017 Arbiter FSM states SHALL be IDLE, SCAN, WRITE, registered; each cycle next state = SCAN if scan_req, else WRITE if buffer non-empty, else IDLE.
REQ-018 Scanout SHALL have absolute priority; a scan_req cycle SHALL never be stalled or dropped.
REQ-019 Scan address SHALL be scan_vidx*H_VIS + scan_hidx computed in FB_ADDR_W bits (shift-add allowed), registered onto mem_addr with mem_en=1, mem_we=0 in the cycle after scan_req.
REQ-020 scan_req with scan_hidx >= H_VIS or scan_vidx >= V_VIS SHALL issue no memory access and produce scan_pix = 0 two cycles later.
REQ-021 scan_pix SHALL equal mem_rdata in the cycle 2 after a valid scan_req, else 0.
REQ-022 WRITE state SHALL pop one buffer entry per cycle, driving mem_en=1, mem_we=1, mem_addr/mem_wdata registered from the head entry.
REQ-023 In IDLE mem_en and mem_we SHALL be 0.
REQ-024 Writes SHALL reach memory in acceptance order; pixel written then scanned at the same address SHALL read the new value once the write cycle precedes the scan cycle.

Reset
REQ-025 On rst_n low: FSM=IDLE, buffer empty, wr_ready=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, scan_pix=0, wr_drop=0.
REQ-026 wr_ready SHALL rise the first cycle after rst_n deasserts; reset mid-operation SHALL discard buffered writes and in-flight fetches.

Configuration
REQ-027 With VGA_FB_ARB_STATS_EN defined, SHALL add output wr_stall_cnt (16 bits): counts cycles with buffer non-empty and state SCAN, saturating at 0xFFFF, cleared by reset.
REQ-028 Without VGA_FB_ARB_STATS_EN, port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-029 Shared package vga_pkg SHALL hold the 480p timing constants (H_VIS, V_VIS, sync/porch counts) and the FSM state typedef.
REQ-030 Write buffer SHALL be sub-module vga_fb_wbuf (sync FIFO, push/pop/full/empty/count).

Verification
REQ-031 Reset then wr_valid=1, addr 0x00005, data 0xABCDEF, no scan_req -> mem_we=1, mem_addr=5, mem_wdata=0xABCDEF within 2 cycles.
REQ-032 scan_req held 640 cycles (hidx 0..639, vidx 1) with 4 writes pending -> mem_we=0 throughout, wr_ready=0 after fill, writes drain in order after scan_req falls.
REQ-033 scan_req hidx=3, vidx=2, mem model returns addr as data -> mem_addr=1283 one cycle later, scan_pix=1283 two cycles after request.
REQ-034 Write addr 307200 -> accepted, no memory write, wr_drop=1 and stays set.
REQ-035 scan_req with hidx=640 -> mem_en=0, scan_pix=0 two cycles later.
REQ-036 rst_n pulsed low with 3 buffered writes -> no subsequent mem_we, all outputs at reset values; with VGA_FB_ARB_STATS_EN, wr_stall_cnt=0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants and the framebuffer arbiter state type.
package vga_pkg;

  // 480p horizontal timing, in pixel clocks
  localparam int VGA_H_VIS   = 640;
  localparam int VGA_H_FP    = 16;
  localparam int VGA_H_SYNC  = 96;
  localparam int VGA_H_BP    = 48;
  localparam int VGA_H_TOTAL = VGA_H_VIS + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  // 480p vertical timing, in lines
  localparam int VGA_V_VIS   = 480;
  localparam int VGA_V_FP    = 10;
  localparam int VGA_V_SYNC  = 2;
  localparam int VGA_V_BP    = 33;
  localparam int VGA_V_TOTAL = VGA_V_VIS + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // Framebuffer port owner for the current cycle
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    WRITE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/vga_fb_wbuf.sv
// Synchronous FIFO holding pending framebuffer writes ({addr, data} entries).
// Push while full and pop while empty are ignored.
module vga_fb_wbuf #(
  parameter int W     = 43,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [W-1:0]  store [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = store[rptr];

  // Read/write pointers and occupancy count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage, cleared on reset so no stale write can ever leak out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) store[i] <= '0;
    end else if (push_ok) begin
      store[wptr] <= din;
    end
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Framebuffer port arbiter: scanout fetches always win the single-port RAM,
// buffered writer traffic drains in the gaps, in acceptance order.
// Optional build macro VGA_FB_ARB_STATS_EN adds the wr_stall_cnt output.
module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter int PIX_W      = 24,
  parameter int FB_ADDR_W  = 19,
  parameter int H_VIS      = VGA_H_VIS,
  parameter int V_VIS      = VGA_V_VIS,
  parameter int WBUF_DEPTH = 4
) (
  input  logic                 clk_25_175M,
  input  logic                 rst_n,
  input  logic                 scan_req,
  input  logic [9:0]           scan_hidx,
  input  logic [9:0]           scan_vidx,
  output logic [PIX_W-1:0]     scan_pix,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [FB_ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]     wr_data,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [FB_ADDR_W-1:0] mem_addr,
  output logic [PIX_W-1:0]     mem_wdata,
  input  logic [PIX_W-1:0]     mem_rdata,
  output logic                 wr_drop
`ifdef VGA_FB_ARB_STATS_EN
  ,
  output logic [15:0]          wr_stall_cnt
`endif
);

  localparam int          ENT_W    = FB_ADDR_W + PIX_W;
  localparam int          CNT_W    = $clog2(WBUF_DEPTH) + 1;
  localparam logic [31:0] H_LIM    = 32'(H_VIS);
  localparam logic [31:0] V_LIM    = 32'(V_VIS);
  localparam logic [31:0] FB_WORDS = 32'(H_VIS * V_VIS);

  arb_state_e           state;
  arb_state_e           next_state;
  logic                 active;
  logic                 buf_full;
  logic                 buf_empty;
  logic [CNT_W-1:0]     buf_count;
  logic [ENT_W-1:0]     head;
  logic                 push;
  logic                 pop;
  logic                 wr_in_range;
  logic                 scan_ok;
  logic [FB_ADDR_W-1:0] scan_addr;
  logic [FB_ADDR_W-1:0] addr_d;
  logic [PIX_W-1:0]     wdata_d;
  logic                 fetch_1;
  logic                 fetch_2;

  // Ready comes only from registered state, so a pop cannot open a slot
  // for a push in the same full cycle.
  assign wr_ready    = active & ~buf_full;
  assign wr_in_range = (32'(wr_addr) < FB_WORDS);
  assign push        = wr_valid & wr_ready & wr_in_range;
  assign pop         = (next_state == WRITE) & ~buf_empty;

  assign scan_ok   = ({22'd0, scan_hidx} < H_LIM) && ({22'd0, scan_vidx} < V_LIM);
  assign scan_addr = FB_ADDR_W'(scan_vidx) * FB_ADDR_W'(H_VIS) + FB_ADDR_W'(scan_hidx);

  // Memory strobes decode straight from registered state/pipeline flags
  assign mem_we   = (state == WRITE);
  assign mem_en   = (state == WRITE) | fetch_1;
  assign scan_pix = fetch_2 ? mem_rdata : '0;

  vga_fb_wbuf #(
    .W     (ENT_W),
    .DEPTH (WBUF_DEPTH)
  ) u_wbuf (
    .clk   (clk_25_175M),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   ({wr_addr, wr_data}),
    .dout  (head),
    .full  (buf_full),
    .empty (buf_empty),
    .count (buf_count)
  );

  // Next owner of the RAM port and the address/data it will present
  always_comb begin
    next_state = IDLE;
    addr_d     = mem_addr;
    wdata_d    = mem_wdata;
    if (scan_req) begin
      next_state = SCAN;
      if (scan_ok) begin
        addr_d = scan_addr;
      end else begin
        addr_d = mem_addr;
      end
    end else if (buf_count != '0) begin
      next_state = WRITE;
      addr_d     = head[ENT_W-1:PIX_W];
      wdata_d    = head[PIX_W-1:0];
    end else begin
      next_state = IDLE;
    end
  end

  // Arbiter state register
  always_ff @(posedge clk_25_175M or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Registered RAM address/data and the two-stage fetch-valid pipeline
  always_ff @(posedge clk_25_175M or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      fetch_1   <= 1'b0;
      fetch_2   <= 1'b0;
    end else begin
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      fetch_1   <= scan_req & scan_ok;
      fetch_2   <= fetch_1;
    end
  end

  // Writer becomes ready one cycle after reset release; drop flag is sticky
  always_ff @(posedge clk_25_175M or negedge rst_n) begin
    if (!rst_n) begin
      active  <= 1'b0;
      wr_drop <= 1'b0;
    end else begin
      active <= 1'b1;
      if (wr_valid && wr_ready && !wr_in_range) wr_drop <= 1'b1;
    end
  end

`ifdef VGA_FB_ARB_STATS_EN
  // Saturating count of cycles where pending writes wait behind scanout
  always_ff @(posedge clk_25_175M or negedge rst_n) begin
    if (!rst_n) begin
      wr_stall_cnt <= 16'd0;
    end else if ((state == SCAN) && !buf_empty && (wr_stall_cnt != 16'hFFFF)) begin
      wr_stall_cnt <= wr_stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed self-checking bench for vga_fb_arbiter with a behavioural
// single-port sync RAM (unwritten words read back as their own address).
`timescale 1ns/1ps
module tb_vga_fb_arbiter;

  localparam int PIX_W     = 24;
  localparam int FB_ADDR_W = 19;

  logic                 clk_25_175M = 1'b0;
  logic                 rst_n;
  logic                 scan_req;
  logic [9:0]           scan_hidx;
  logic [9:0]           scan_vidx;
  logic [PIX_W-1:0]     scan_pix;
  logic                 wr_valid;
  logic                 wr_ready;
  logic [FB_ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]     wr_data;
  logic                 mem_en;
  logic                 mem_we;
  logic [FB_ADDR_W-1:0] mem_addr;
  logic [PIX_W-1:0]     mem_wdata;
  logic [PIX_W-1:0]     mem_rdata = '0;
  logic                 wr_drop;
`ifdef VGA_FB_ARB_STATS_EN
  logic [15:0]          wr_stall_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int we_cnt = 0;
  logic [42:0] wlog [$];

  logic [PIX_W-1:0] ram  [0:524287];
  bit               seen [0:524287];

  vga_fb_arbiter dut (
    .clk_25_175M (clk_25_175M),
    .rst_n       (rst_n),
    .scan_req    (scan_req),
    .scan_hidx   (scan_hidx),
    .scan_vidx   (scan_vidx),
    .scan_pix    (scan_pix),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .wr_drop     (wr_drop)
`ifdef VGA_FB_ARB_STATS_EN
    ,
    .wr_stall_cnt (wr_stall_cnt)
`endif
  );

  always #20 clk_25_175M = ~clk_25_175M;

  // Single-port sync RAM with one-cycle read latency, plus a write log
  always @(posedge clk_25_175M) begin
    if (mem_en && mem_we) begin
      ram[mem_addr]  <= mem_wdata;
      seen[mem_addr] <= 1'b1;
      we_cnt         <= we_cnt + 1;
      wlog.push_back({mem_addr, mem_wdata});
    end
    if (mem_en && !mem_we) begin
      mem_rdata <= seen[mem_addr] ? ram[mem_addr] : 24'(mem_addr);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_25_175M);
    @(negedge clk_25_175M);
  endtask

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_wr_ready"},  32'(wr_ready),  32'd0);
    chk({pfx, "_mem_en"},    32'(mem_en),    32'd0);
    chk({pfx, "_mem_we"},    32'(mem_we),    32'd0);
    chk({pfx, "_mem_addr"},  32'(mem_addr),  32'd0);
    chk({pfx, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    chk({pfx, "_scan_pix"},  32'(scan_pix),  32'd0);
    chk({pfx, "_wr_drop"},   32'(wr_drop),   32'd0);
`ifdef VGA_FB_ARB_STATS_EN
    chk({pfx, "_stall_cnt"}, 32'(wr_stall_cnt), 32'd0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w0;
    int pushed;
    logic accept;

    rst_n = 1'b0; scan_req = 1'b0; scan_hidx = 10'd0; scan_vidx = 10'd0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (2) @(negedge clk_25_175M);
    check_reset_outputs("rst");

    // Release reset; ready follows one edge later
    rst_n = 1'b1;
    #1;
    chk("ready_before_edge", 32'(wr_ready), 32'd0);
    tick();
    chk("ready_rise", 32'(wr_ready), 32'd1);

    // Single write reaches memory two edges after acceptance
    wr_valid = 1'b1; wr_addr = 19'd5; wr_data = 24'hABCDEF;
    tick();
    wr_valid = 1'b0;
    chk("w1_we_early", 32'(mem_we), 32'd0);
    tick();
    chk("w1_we",    32'(mem_we),    32'd1);
    chk("w1_en",    32'(mem_en),    32'd1);
    chk("w1_addr",  32'(mem_addr),  32'd5);
    chk("w1_wdata", 32'(mem_wdata), 32'hABCDEF);
    tick();
    chk("w1_idle_en", 32'(mem_en), 32'd0);

    // Scan fetch at (3,2): address 2*640+3, RAM returns address
    scan_req = 1'b1; scan_hidx = 10'd3; scan_vidx = 10'd2;
    tick();
    scan_req = 1'b0;
    chk("s1_en",   32'(mem_en),   32'd1);
    chk("s1_we",   32'(mem_we),   32'd0);
    chk("s1_addr", 32'(mem_addr), 32'd1283);
    chk("s1_pix_early", 32'(scan_pix), 32'd0);
    tick();
    chk("s1_pix", 32'(scan_pix), 32'd1283);
    tick();
    chk("s1_pix_after", 32'(scan_pix), 32'd0);

    // Write then scan the same pixel: new value is read
    wr_valid = 1'b1; wr_addr = 19'd1283; wr_data = 24'h123456;
    tick();
    wr_valid = 1'b0;
    tick();
    chk("ws_we", 32'(mem_we), 32'd1);
    scan_req = 1'b1; scan_hidx = 10'd3; scan_vidx = 10'd2;
    tick();
    scan_req = 1'b0;
    tick();
    chk("ws_pix", 32'(scan_pix), 32'h123456);

    // Out-of-range scan coordinates: no access, zero pixel
    scan_req = 1'b1; scan_hidx = 10'd640; scan_vidx = 10'd0;
    tick();
    scan_req = 1'b0;
    chk("oob_h_en", 32'(mem_en), 32'd0);
    tick();
    chk("oob_h_pix", 32'(scan_pix), 32'd0);
    scan_req = 1'b1; scan_hidx = 10'd0; scan_vidx = 10'd480;
    tick();
    scan_req = 1'b0;
    chk("oob_v_en", 32'(mem_en), 32'd0);
    tick();
    chk("oob_v_pix", 32'(scan_pix), 32'd0);

    // Out-of-range write is accepted and dropped; flag is sticky
    chk("drop_clear", 32'(wr_drop), 32'd0);
    w0 = we_cnt;
    wr_valid = 1'b1; wr_addr = 19'd307200; wr_data = 24'h111111;
    chk("drop_ready", 32'(wr_ready), 32'd1);
    tick();
    wr_valid = 1'b0;
    chk("drop_set", 32'(wr_drop), 32'd1);
    tick(); tick();
    chk("drop_no_we", 32'(we_cnt - w0), 32'd0);
    wr_valid = 1'b1; wr_addr = 19'd307199; wr_data = 24'h222222;
    tick();
    wr_valid = 1'b0;
    tick(); tick();
    chk("last_pix_we", 32'(we_cnt - w0), 32'd1);
    chk("last_pix_addr", 32'(mem_addr), 32'd307199);
    chk("drop_sticky", 32'(wr_drop), 32'd1);

    // Full scan line while the writer fills the buffer
    wlog.delete();
    w0 = we_cnt;
    pushed = 0;
    scan_req = 1'b1; scan_vidx = 10'd1;
    for (int i = 0; i < 640; i++) begin
      scan_hidx = 10'(i);
      wr_valid  = (pushed < 5);
      wr_addr   = 19'(1000 + pushed);
      wr_data   = 24'hC00000 + 24'(pushed);
      accept    = wr_valid && wr_ready;
      tick();
      if (accept) pushed++;
      if (i == 20) chk("line_addr", 32'(mem_addr), 32'd660);
    end
    chk("line_pushed", 32'(pushed), 32'd4);
    chk("line_full_ready", 32'(wr_ready), 32'd0);
    chk("line_no_we", 32'(we_cnt - w0), 32'd0);
    scan_req = 1'b0;
    for (int k = 0; k < 30 && wlog.size() < 5; k++) begin
      wr_valid = (pushed < 5);
      wr_addr  = 19'(1000 + pushed);
      wr_data  = 24'hC00000 + 24'(pushed);
      accept   = wr_valid && wr_ready;
      tick();
      if (accept) pushed++;
    end
    wr_valid = 1'b0;
    chk("drain_cnt", 32'(wlog.size()), 32'd5);
    for (int k = 0; k < 5; k++) begin
      if (k < wlog.size()) begin
        chk($sformatf("drain_addr%0d", k), 32'(wlog[k][42:24]), 32'(1000 + k));
        chk($sformatf("drain_data%0d", k), 32'(wlog[k][23:0]), 32'h00C00000 + 32'(k));
      end
    end

    // Reset with three writes held behind scanout
    tick(); tick();
    pushed = 0;
    scan_req = 1'b1; scan_hidx = 10'd0; scan_vidx = 10'd0;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_addr = 19'(2000 + i); wr_data = 24'h0000AA;
      accept = wr_ready;
      tick();
      if (accept) pushed++;
    end
    chk("pre_rst_pushed", 32'(pushed), 32'd3);
    rst_n = 1'b0; scan_req = 1'b0; wr_valid = 1'b0;
    w0 = we_cnt;
    #1;
    check_reset_outputs("mid_rst");
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("post_rst_no_we", 32'(we_cnt - w0), 32'd0);
    chk("post_rst_ready", 32'(wr_ready), 32'd1);
    chk("post_rst_en",    32'(mem_en),   32'd0);
    chk("post_rst_pix",   32'(scan_pix), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
